// File: rtl/clk_switch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// clk_sw_pkg
// Shared types and constants for the clock-switch request controller.
//   state_t : controller FSM states
//   SEL_A   : sel encoding that selects clk_a (matches the switch's sel input)
//   SEL_B   : sel encoding that selects clk_b
//   max_u() : small helper used for derived widths
// -----------------------------------------------------------------------------
package clk_sw_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_OFF = 2'd1,
        WAIT_ON  = 2'd2,
        SETTLE   = 2'd3
    } state_t;

    localparam logic SEL_A = 1'b1;
    localparam logic SEL_B = 1'b0;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/clk_switch_ctrl_if.sv
// -----------------------------------------------------------------------------
// clk_switch_ctrl_if
// Bundles the request handshake, the switch sel/enable-status path and the
// status outputs of the clock-switch controller.
//   req_valid / req_sel / req_ready : select request handshake
//   sel                             : drives the switch sel input
//   en_a_async / en_b_async         : switch per-clock enable flop outputs
//   busy / done / cur_sel / err     : controller status
//   err_clr                         : clears the sticky err flag
// Modports:
//   master : requester side (CSR/power manager plus the switch itself)
//   slave  : the controller
// -----------------------------------------------------------------------------
interface clk_switch_ctrl_if;

    logic req_valid;
    logic req_sel;
    logic req_ready;
    logic sel;
    logic en_a_async;
    logic en_b_async;
    logic busy;
    logic done;
    logic cur_sel;
    logic err;
    logic err_clr;

    modport master (
        output req_valid, req_sel, en_a_async, en_b_async, err_clr,
        input  req_ready, sel, busy, done, cur_sel, err
    );

    modport slave (
        input  req_valid, req_sel, en_a_async, en_b_async, err_clr,
        output req_ready, sel, busy, done, cur_sel, err
    );

endinterface

// File: rtl/clk_switch_ctrl_sync_ff.sv
// -----------------------------------------------------------------------------
// sync_ff
// Multi-flop synchronizer for a single asynchronous level into the i_clk
// domain. All stages reset asynchronously to RST_VAL.
//   i_clk : destination clock
//   i_rst : asynchronous reset, active-high
//   i_d   : asynchronous input level
//   o_q   : synchronized output (last stage)
// -----------------------------------------------------------------------------
module sync_ff #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    // Stage 0 samples the asynchronous input; later stages resolve metastability.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= {STAGES{RST_VAL}};
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/clk_switch_ctrl.sv
// -----------------------------------------------------------------------------
// clk_switch_ctrl
// Request-side controller for a glitch-free clock switch. Accepts select
// requests, drives the switch sel input, watches the switch's synchronized
// per-clock enable status and reports completion only after the old clock is
// off, the new clock is on and a settle period has elapsed. A hand-over that
// does not finish within TIMEOUT_CYC cycles reverts sel and sets sticky err.
// Ports:
//   i_clk  : always-on control clock, independent of clk_a/clk_b
//   i_rst  : asynchronous reset, active-high
//   io_ctl : clk_switch_ctrl_if.slave (request handshake, sel, enable status,
//            busy/done/cur_sel/err status, err_clr)
// -----------------------------------------------------------------------------
module clk_switch_ctrl
    import clk_sw_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int SETTLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 1024,
    parameter int CNT_W       = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    clk_switch_ctrl_if.slave  io_ctl
);

    // The shared counter must also hold the settle count.
    localparam int SETTLE_W = $clog2(SETTLE_CYC + 1);
    localparam int W        = int'(max_u(CNT_W, SETTLE_W));

    localparam logic [W:0] TMO_LIM    = (W+1)'(TIMEOUT_CYC);
    localparam logic [W:0] SETTLE_LIM = (W+1)'(SETTLE_CYC);

    // ------------------------------------------------------------------
    // Enable status synchronizers: index 1 = clk_a path, index 0 = clk_b
    // ------------------------------------------------------------------
    logic [1:0] w_en_async;
    logic [1:0] w_en_sync;

    assign w_en_async = {io_ctl.en_a_async, io_ctl.en_b_async};

    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
        sync_ff #(
            .STAGES  (SYNC_STAGES),
            .RST_VAL (1'b0)
        ) u_sync (
            .i_clk (i_clk),
            .i_rst (i_rst),
            .i_d   (w_en_async[gi]),
            .o_q   (w_en_sync[gi])
        );
    end

    logic w_en_a;
    logic w_en_b;
    assign w_en_a = w_en_sync[1];
    assign w_en_b = w_en_sync[0];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t         r_state;
    state_t         w_state_next;
    logic           r_sel;
    logic           w_sel_next;
    logic           r_cur_sel;
    logic           w_cur_sel_next;
    logic [W-1:0]   r_cnt;
    logic [W-1:0]   w_cnt_next;
    logic           r_done;
    logic           w_done_next;
    logic           r_err;
    logic           w_err_next;

    logic           w_req_ready;
    logic           w_accept;
    logic           w_en_old;
    logic           w_en_new;
    logic [W:0]     w_cnt_inc;
    logic           w_tmo_hit;
    logic           w_settle_end;
    logic           w_err_set;

    // Ready is forced low while reset is held, not just after the first edge.
    assign w_req_ready = (r_state == IDLE) && !i_rst;
    assign w_accept    = io_ctl.req_valid && w_req_ready;

    // Old/new path are relative to the sel currently driven to the switch.
    assign w_en_old = (r_sel == SEL_A) ? w_en_b : w_en_a;
    assign w_en_new = (r_sel == SEL_A) ? w_en_a : w_en_b;

    // One extra bit so the compare sees the value the counter would reach.
    assign w_cnt_inc    = {1'b0, r_cnt} + (W+1)'(1);
    assign w_tmo_hit    = (w_cnt_inc >= TMO_LIM);
    // With SETTLE_CYC = 0 this is true on the first SETTLE cycle.
    assign w_settle_end = (w_cnt_inc >= SETTLE_LIM);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_sel     <= SEL_A;
            r_cur_sel <= SEL_A;
            r_cnt     <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_sel     <= w_sel_next;
            r_cur_sel <= w_cur_sel_next;
            r_cnt     <= w_cnt_next;
            r_done    <= w_done_next;
            r_err     <= w_err_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_sel_next     = r_sel;
        w_cur_sel_next = r_cur_sel;
        w_cnt_next     = r_cnt;
        w_done_next    = 1'b0;
        w_err_set      = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (io_ctl.req_sel == r_cur_sel) begin
                        // Already on the requested source: just acknowledge.
                        w_done_next = 1'b1;
                    end else begin
                        w_sel_next   = io_ctl.req_sel;
                        w_cnt_next   = '0;
                        w_state_next = WAIT_OFF;
                    end
                end
            end

            WAIT_OFF: begin
                w_cnt_next = w_cnt_inc[W-1:0];
                // Timeout wins over leaving WAIT_OFF so the total budget
                // from the sel change is never exceeded.
                if (w_tmo_hit) begin
                    w_err_set      = 1'b1;
                    w_sel_next     = r_cur_sel;
                    w_state_next   = IDLE;
                end else if (!w_en_old) begin
                    w_state_next = WAIT_ON;
                end
            end

            WAIT_ON: begin
                // Seeing the new clock on at the deadline still counts as success.
                if (w_en_new) begin
                    w_cnt_next   = '0;
                    w_state_next = SETTLE;
                end else if (w_tmo_hit) begin
                    w_err_set    = 1'b1;
                    w_sel_next   = r_cur_sel;
                    w_state_next = IDLE;
                end else begin
                    w_cnt_next = w_cnt_inc[W-1:0];
                end
            end

            SETTLE: begin
                if (w_settle_end) begin
                    w_cur_sel_next = r_sel;
                    w_done_next    = 1'b1;
                    w_state_next   = IDLE;
                end else begin
                    w_cnt_next = w_cnt_inc[W-1:0];
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase

        // Clear has priority over a timeout in the same cycle.
        w_err_next = io_ctl.err_clr ? 1'b0 : (r_err | w_err_set);
    end

    // The switch keeps the new enable high once it has handed over; a drop
    // here means the switch misbehaved, which the controller does not recheck.
    a_settle_en_stable: assert property (
        @(posedge i_clk) disable iff (i_rst)
        (r_state == SETTLE) |-> w_en_new
    );

    assign io_ctl.req_ready = w_req_ready;
    assign io_ctl.sel       = r_sel;
    assign io_ctl.busy      = (r_state != IDLE);
    assign io_ctl.done      = r_done;
    assign io_ctl.cur_sel   = r_cur_sel;
    assign io_ctl.err       = r_err;

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clk_switch_ctrl
// Bench for clk_switch_ctrl with a small behavioural clock-switch plant that
// hands enables over after programmable delays, a request-level reference
// model, a per-cycle output compare and directed literal checks.
// -----------------------------------------------------------------------------
module tb_clk_switch_ctrl;

    localparam int S_STG = 2;
    localparam int S_SET = 4;
    localparam int S_TMO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #10 clk = ~clk;

    clk_switch_ctrl_if io();

    clk_switch_ctrl #(
        .SYNC_STAGES (S_STG),
        .SETTLE_CYC  (S_SET),
        .TIMEOUT_CYC (S_TMO)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_ctl (io)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    endtask

    task automatic chkn(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Reference model: request-level view of a hand-over.
    // phase 0 = idle, 1 = waiting for old clock off, 2 = waiting for new
    // clock on, 3 = settling. m_t counts cycles since the sel change.
    // ------------------------------------------------------------------
    int   m_phase = 0;
    int   m_t     = 0;
    int   m_left  = 0;
    logic m_sel   = 1'b1;
    logic m_cur   = 1'b1;
    logic m_err   = 1'b0;
    logic m_done  = 1'b0;
    logic qa[$];
    logic qb[$];
    logic m_sa, m_sb, m_old, m_new, m_tmo, m_dn;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0; m_t = 0; m_left = 0;
            m_sel = 1'b1; m_cur = 1'b1; m_err = 1'b0; m_done = 1'b0;
            qa.delete(); qb.delete();
            for (int i = 0; i < S_STG; i++) begin
                qa.push_back(1'b0);
                qb.push_back(1'b0);
            end
        end else begin
            // Controller sees the enable levels from S_STG edges ago.
            m_sa = qa[0]; m_sb = qb[0];
            void'(qa.pop_front()); void'(qb.pop_front());
            qa.push_back(io.en_a_async);
            qb.push_back(io.en_b_async);
            m_old = m_sel ? m_sb : m_sa;
            m_new = m_sel ? m_sa : m_sb;
            m_tmo = 1'b0;
            m_dn  = 1'b0;
            if (m_phase == 0) begin
                if (io.req_valid) begin
                    if (io.req_sel == m_cur) m_dn = 1'b1;
                    else begin
                        m_sel = io.req_sel; m_phase = 1; m_t = 0;
                    end
                end
            end else if (m_phase == 3) begin
                m_left--;
                if (m_left == 0) begin
                    m_cur = m_sel; m_dn = 1'b1; m_phase = 0;
                end
            end else begin
                m_t++;
                if (m_phase == 1) begin
                    if (m_t >= S_TMO) m_tmo = 1'b1;
                    else if (!m_old) m_phase = 2;
                end else begin
                    if (m_new) begin
                        m_phase = 3;
                        m_left  = (S_SET > 0) ? S_SET : 1;
                    end else if (m_t >= S_TMO) m_tmo = 1'b1;
                end
                if (m_tmo) begin
                    m_sel = m_cur; m_phase = 0;
                end
            end
            m_done = m_dn;
            m_err  = io.err_clr ? 1'b0 : (m_err | m_tmo);
        end
    end

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk1("sel",       io.sel,       m_sel);
            chk1("cur_sel",   io.cur_sel,   m_cur);
            chk1("busy",      io.busy,      m_phase != 0);
            chk1("done",      io.done,      m_done);
            chk1("err",       io.err,       m_err);
            chk1("req_ready", io.req_ready, m_phase == 0);
        end
    end

    // ------------------------------------------------------------------
    // Clock-switch plant: after sel changes, drops the old enable d_off
    // cycles later, then raises the new one d_on cycles after the change.
    // ------------------------------------------------------------------
    int   d_off     = 3;
    int   d_on      = 5;
    logic stuck_cfg = 1'b0;
    logic sw_stuck  = 1'b0;
    logic sw_tgt    = 1'b1;
    int   sw_cnt    = 0;

    task automatic sw_step();
        if (sw_tgt !== io.sel) begin
            sw_tgt   = io.sel;
            sw_cnt   = 0;
            sw_stuck = stuck_cfg;
        end
        sw_cnt++;
        if (sw_tgt) begin
            if (io.en_b_async && sw_cnt >= d_off) io.en_b_async = 1'b0;
            else if (!io.en_b_async && !io.en_a_async && sw_cnt >= d_on && !sw_stuck)
                io.en_a_async = 1'b1;
        end else begin
            if (io.en_a_async && sw_cnt >= d_off) io.en_a_async = 1'b0;
            else if (!io.en_a_async && !io.en_b_async && sw_cnt >= d_on && !sw_stuck)
                io.en_b_async = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        sw_step();
    endtask

    task automatic wait_done(input string name, output int k);
        k = 0;
        while (!io.done && k < 80) begin
            tick();
            k++;
        end
        if (k >= 80) chkn({name, "_timeout"}, k, -1);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (m_phase != 0 && k < 80) begin
            tick();
            k++;
        end
        if (k >= 80) chkn("idle_timeout", k, -1);
    endtask

    int lat;

    initial begin
        io.req_valid  = 1'b0;
        io.req_sel    = 1'b1;
        io.err_clr    = 1'b0;
        io.en_a_async = 1'b1;
        io.en_b_async = 1'b0;

        repeat (3) tick();
        chk1("rst_ready_low", io.req_ready, 1'b0);
        rst = 1'b0;
        tick();

        // Reset values
        chk1("rst_sel",     io.sel,       1'b1);
        chk1("rst_cur_sel", io.cur_sel,   1'b1);
        chk1("rst_busy",    io.busy,      1'b0);
        chk1("rst_err",     io.err,       1'b0);
        chk1("rst_ready",   io.req_ready, 1'b1);

        // Same-source request: done exactly one cycle after accept
        io.req_valid = 1'b1; io.req_sel = 1'b1;
        tick();
        io.req_valid = 1'b0;
        chk1("same_done", io.done, 1'b1);
        chk1("same_sel",  io.sel,  1'b1);
        tick();
        chk1("same_done_off", io.done, 1'b0);

        // Timeout A->B: en_b never comes up
        stuck_cfg = 1'b1;
        io.req_valid = 1'b1; io.req_sel = 1'b0;
        tick();
        io.req_valid = 1'b0;
        chk1("tmo_sel_b", io.sel, 1'b0);
        repeat (15) tick();
        chk1("tmo_err_pre",  io.err,  1'b0);
        chk1("tmo_busy_pre", io.busy, 1'b1);
        stuck_cfg = 1'b0;
        tick();
        chk1("tmo_err",    io.err,       1'b1);
        chk1("tmo_revert", io.sel,       1'b1);
        chk1("tmo_nodone", io.done,      1'b0);
        chk1("tmo_ready",  io.req_ready, 1'b1);
        repeat (12) tick();

        // Second timeout with err_clr on the same edge as the set
        stuck_cfg = 1'b1;
        io.req_valid = 1'b1; io.req_sel = 1'b0;
        tick();
        io.req_valid = 1'b0;
        repeat (15) tick();
        chk1("err_sticky", io.err, 1'b1);
        stuck_cfg  = 1'b0;
        io.err_clr = 1'b1;
        tick();
        io.err_clr = 1'b0;
        chk1("clr_wins",    io.err,  1'b0);
        chk1("clr_revert",  io.sel,  1'b1);
        chk1("clr_idle",    io.busy, 1'b0);
        tick();
        chk1("clr_stays",   io.err,  1'b0);
        repeat (12) tick();

        // Normal A->B, plant drops en_a after 3 and raises en_b after 5
        d_off = 3; d_on = 5;
        io.req_valid = 1'b1; io.req_sel = 1'b0;
        tick();
        io.req_valid = 1'b0;
        chk1("ab_sel",  io.sel,  1'b0);
        chk1("ab_busy", io.busy, 1'b1);
        wait_done("ab", lat);
        chkn("ab_latency", lat, 11);
        chk1("ab_cur_sel", io.cur_sel, 1'b0);
        chk1("ab_idle",    io.busy,    1'b0);
        repeat (4) tick();

        // Back to A, then backpressure during an A->B switch
        io.req_valid = 1'b1; io.req_sel = 1'b1;
        tick();
        io.req_valid = 1'b0;
        wait_done("ba", lat);
        chk1("ba_cur_sel", io.cur_sel, 1'b1);
        repeat (4) tick();
        io.req_valid = 1'b1; io.req_sel = 1'b0;
        tick();
        io.req_sel = 1'b1;      // held request while busy
        chk1("bp_busy", io.busy, 1'b1);
        tick();
        chk1("bp_not_taken", io.sel, 1'b0);
        wait_done("bp_ab", lat);
        chk1("bp_cur_b",  io.cur_sel,   1'b0);
        chk1("bp_ready",  io.req_ready, 1'b1);
        tick();
        io.req_valid = 1'b0;
        chk1("bp_taken_busy", io.busy, 1'b1);
        chk1("bp_taken_sel",  io.sel,  1'b1);
        wait_done("bp_ba", lat);
        chk1("bp_cur_a", io.cur_sel, 1'b1);

        // Randomized traffic checked by the model each cycle
        for (int i = 0; i < 500; i++) begin
            io.req_valid = ($urandom_range(0, 3) == 0);
            io.req_sel   = 1'($urandom_range(0, 1));
            io.err_clr   = ($urandom_range(0, 15) == 0);
            stuck_cfg    = ($urandom_range(0, 15) == 0);
            d_off        = $urandom_range(1, 4);
            d_on         = d_off + $urandom_range(1, 4);
            tick();
        end
        io.req_valid = 1'b0;
        io.err_clr   = 1'b0;
        stuck_cfg    = 1'b0;
        wait_idle();
        repeat (16) tick();

        // Asynchronous reset while waiting for the new clock
        d_off = 1; d_on = 8;
        io.req_valid = 1'b1; io.req_sel = ~m_cur;
        tick();
        io.req_valid = 1'b0;
        lat = 0;
        while (m_phase != 2 && lat < 20) begin
            tick();
            lat++;
        end
        chk1("rst_mid_in_wait_on", io.busy, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk1("rst_mid_sel",   io.sel,       1'b1);
        chk1("rst_mid_cur",   io.cur_sel,   1'b1);
        chk1("rst_mid_busy",  io.busy,      1'b0);
        chk1("rst_mid_done",  io.done,      1'b0);
        chk1("rst_mid_err",   io.err,       1'b0);
        chk1("rst_mid_ready", io.req_ready, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        d_off = 3; d_on = 5;
        repeat (12) tick();
        io.req_valid = 1'b1; io.req_sel = 1'b0;
        tick();
        io.req_valid = 1'b0;
        wait_done("post_rst", lat);
        chk1("post_rst_cur", io.cur_sel, 1'b0);
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
